// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared op codes, multiply/divide state encoding and helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] MDS_IDLE = 2'd0;
    localparam logic [1:0] MDS_RUN  = 2'd1;
    localparam logic [1:0] MDS_FIX  = 2'd2;

    // Divide by zero: LO is filled with this bit, HI returns the original dividend.
    localparam logic DIV0_QUOT_FILL    = 1'b1;
    localparam logic DIV0_REM_DIVIDEND = 1'b1;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module : muldiv_seq
// Brief  : Radix-2 sequential multiply/divide core with HI/LO registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic             r_done;
    logic             w_busy;

    logic             w_accept;
    logic             w_launch;
    logic             w_op_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept = i_start && (r_state == MDS_IDLE);
    assign w_launch = w_accept && !i_op[2];
    assign w_op_div = md_is_div(i_op);
    assign w_a_neg  = md_is_signed(i_op) && i_a[WIDTH-1];
    assign w_b_neg  = md_is_signed(i_op) && i_b[WIDTH-1];
    assign w_b_zero = (i_b == '0);
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // Multiply: r_acc is the upper product half, r_q holds multiplier/lower half.
    assign w_add   = {1'b0, r_acc} + ({1'b0, r_b} & {(WIDTH+1){r_q[0]}});
    // Divide: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
    assign w_rs    = {r_acc, r_q[WIDTH-1]};
    assign w_trial = w_rs - {1'b0, r_b};

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_q ? -r_q : r_q;
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MDS_IDLE: if (w_launch) w_next = MDS_RUN;
            MDS_RUN:  if (r_cnt == '0) w_next = MDS_FIX;
            MDS_FIX:  w_next = MDS_IDLE;
            default:  w_next = MDS_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != MDS_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == MDS_FIX);
            case (r_state)
                MDS_IDLE: begin
                    if (w_launch) begin
                        r_acc    <= '0;
                        r_q      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_cnt    <= c_CNT_INIT;
                        r_is_div <= w_op_div;
                        // A zero divisor leaves the quotient unsigned so it stays all ones.
                        r_neg_q  <= (w_a_neg ^ w_b_neg) && !(w_op_div && w_b_zero);
                        r_neg_r  <= w_op_div && w_a_neg && DIV0_REM_DIVIDEND;
                        r_div0   <= w_op_div && w_b_zero;
                    end else if (w_accept && (i_op == MD_MTHI)) begin
                        r_hi <= i_a;
                    end else if (w_accept && (i_op == MD_MTLO)) begin
                        r_lo <= i_a;
                    end
                end
                MDS_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            r_acc <= w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_rs[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_add[WIDTH:1];
                        r_q   <= {w_add[0], r_q[WIDTH-1:1]};
                    end
                end
                MDS_FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_div0 ? {WIDTH{DIV0_QUOT_FILL}} : w_quot_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = w_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module : alu_muldiv
// Brief  : Combinational MIPS ALU plus sequential multiply/divide unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] var1,
    input  logic [WIDTH-1:0] var2,
    input  logic [3:0]       aluControl,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             overflow,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_ovf;

    assign w_sh   = var1[SHW-1:0];
    assign w_sum  = var1 + var2;
    assign w_diff = var1 - var2;
    assign w_lt_s = $signed(var1) < $signed(var2);
    assign w_lt_u = var1 < var2;

    assign w_ovf_add = (var1[WIDTH-1] == var2[WIDTH-1]) && (w_sum[WIDTH-1] != var1[WIDTH-1]);
    assign w_ovf_sub = (var1[WIDTH-1] != var2[WIDTH-1]) && (w_diff[WIDTH-1] != var1[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (aluControl)
            ALU_AND:  w_res = var1 & var2;
            ALU_OR:   w_res = var1 | var2;
            ALU_ADD:  begin w_res = w_sum;  w_ovf = w_ovf_add; end
            ALU_XOR:  w_res = var1 ^ var2;
            ALU_NOR:  w_res = ~(var1 | var2);
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
            ALU_SUB:  begin w_res = w_diff; w_ovf = w_ovf_sub; end
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
            ALU_SLL:  w_res = var2 << w_sh;
            ALU_SRL:  w_res = var2 >> w_sh;
            ALU_SRA:  w_res = $unsigned($signed(var2) >>> w_sh);
            ALU_LUI:  w_res = {var2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:  w_res = '0;
        endcase
    end

    assign aluout   = w_res;
    assign zero     = (w_res == '0);
    assign overflow = w_ovf;

    muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (reset),
        .i_a     (var1),
        .i_b     (var2),
        .i_op    (md_op),
        .i_start (md_start),
        .o_busy  (md_busy),
        .o_done  (md_done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

endmodule

`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU, for the MIPS datapath.
- Keeps a combinational integer ALU with an extended op set, a signed overflow flag, and a zero flag valid for every op.
- Adds a sequential multiply/divide unit with HI/LO registers and a start/busy/done handshake. The control unit stalls on md_busy.

Parameters:
- WIDTH, 32, datapath width in bits. Must be even and ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- var1  in  WIDTH  operand A; shift amount taken from var1[SHW-1:0]; MTHI/MTLO source.
- var2  in  WIDTH  operand B; value shifted for shift ops.
- aluControl  in  4  combinational op select.
- aluout  out  WIDTH  combinational result.
- zero  out  1  aluout == 0, for every op.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- md_start  in  1  request, sampled on the clock edge.
- md_busy  out  1  multiply/divide unit running.
- md_done  out  1  one-cycle pulse; hi/lo updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Combinational aluControl codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0101 SLTU (unsigned var1<var2 → 1 else 0); 0110 SUB; 0111 SLT (signed).
  - 1000 SLL var2<<sh; 1001 SRL; 1010 SRA (sign fill), where sh = var1[SHW-1:0].
  - 1011 LUI: var2[WIDTH/2-1:0] placed in upper half, lower half zero.
  - All other codes: aluout = 0 (never X).
- overflow: ADD when operand signs equal and result sign differs; SUB when operand signs differ and result sign ≠ var1 sign.
- Multiply/divide state machine: IDLE → RUN → FIX → IDLE.
  - md_busy = (state != IDLE), registered state.
- IDLE, md_start=1:
  - md_op 0–3: latch magnitudes (signed ops) or raw values (unsigned ops), latch result signs, load counter = WIDTH-1, go to RUN.
  - md_op 4/5: write hi (4) or lo (5) from var1 on that edge. Stay IDLE; no md_done.
  - md_op 6/7: ignored.
- RUN: one radix-2 iteration per edge, WIDTH iterations.
  - Multiply: shift-add into a 2·WIDTH product.
  - Divide: restoring shift-subtract.
  - Counter reaching 0 → FIX.
- FIX, one edge:
  - Apply sign correction.
  - Write hi/lo: multiply hi = product upper half, lo = lower half; divide lo = quotient, hi = remainder.
  - Register md_done=1; go to IDLE.
- Latency: start sampled on edge E0; md_busy high for WIDTH+1 cycles; hi/lo new and md_done=1 in the cycle after edge E0+WIDTH+1 (33 cycles for WIDTH=32). md_busy is 0 in that cycle.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1 → lo = MIN, hi = 0.
- Divide by zero, all four ops, normal latency: lo = all ones, hi = dividend (original, unsigned view).
- md_start while md_busy: ignored entirely (including MTHI/MTLO); operands changing during RUN have no effect.
- md_start in the md_done cycle: accepted (unit is IDLE).
- hi/lo hold their values during RUN and change only in FIX or on MTHI/MTLO.
- Reset, asynchronous and active-high, including mid-operation:
  - state = IDLE; md_busy = 0; md_done = 0; hi = 0; lo = 0; internal accumulators and counter = 0.
  - An in-flight operation is discarded.
- Combinational outputs are independent of the multiply/divide state.

Decomposition:
- Shared package alu_pkg:
  - aluControl code constants, md_op constants.
  - Multiply/divide state encoding (IDLE/RUN/FIX).
  - DIV0 result rule documented as constants.
- Sub-module muldiv_seq: sequential multiply/divide core with its own handshake, hi/lo registers and the state machine.
- alu_muldiv top: combinational ALU plus a muldiv_seq instance.

Test Plan:
- WIDTH=32 combinational sweep:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1.
  - SUB 5-5 → 0, zero=1.
  - SLT -1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI 0x1234 → 0x12340000.
  - Code 1111 → 0.
- MULT -3 × 7: md_busy high 33 cycles, then md_done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=0x00000001.
- Divide:
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 → lo=14, hi=2.
  - DIV 0x80000000/-1 → lo=0x80000000, hi=0.
  - DIVU 9/0 → lo=0xFFFFFFFF, hi=9.
- Handshake:
  - md_start MULT during RUN → ignored; result is that of the first op.
  - md_start in the md_done cycle → second op accepted, its md_done 33 cycles later.
  - MTHI 0xA5A5A5A5 while idle → hi updated next edge, md_done stays 0.
- Reset asserted mid-RUN (cycle 10) → md_busy=0, hi=lo=0 immediately; no md_done after release.
- WIDTH=8: MULT -128×-128 → hi=0x40, lo=0x00, md_done 9 cycles after start.
